pdp8_seq_cov_monitor: RTL and testbench
=======================================

Name: pdp8_seq_cov_monitor

Overview:
Parametrised, synthesizable instruction-sequence coverage monitor for the PDP8 simulator bench.
- Tracks NUM_SEQ independently programmable instruction-class sequences, each up to MAX_LEN steps, against the decoded instruction stream.
- Counts completed sequences per channel.
- Replaces the single hard-wired CLA_CLL/TAD/TAD/DCA/HLT/JMP edge-triggered coverage FSM with a clk-synchronous, configurable engine instantiated beside the decode/exec checkers.

Parameters:
- NUM_SEQ, 4, number of independent sequence channels (1..16).
- MAX_LEN, 8, maximum steps per sequence (2..32).
- OPC_W, 5, width of encoded instruction-class code (covers 6 mem opcodes + 22 op7 opcodes).
- CNT_W, 16, width of each per-channel match counter.
- TIMEOUT_CYC, 64, idle-gap limit in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset.
- instr_valid  in  1  one-cycle strobe, one per decoded instruction.
- instr_class  in  OPC_W  encoded class of the instruction, qualified by instr_valid.
- cfg_wr  in  1  write one pattern step.
- cfg_len_wr  in  1  write sequence length.
- cfg_sel  in  $clog2(NUM_SEQ) (min 1)  target channel.
- cfg_step  in  $clog2(MAX_LEN)  step index for cfg_wr.
- cfg_class  in  OPC_W  class code for cfg_wr.
- cfg_len  in  $clog2(MAX_LEN)+1  sequence length for cfg_len_wr; 0 disables the channel.
- clr_counts  in  1  synchronous clear of all counters and sat flags.
- match_pulse  out  NUM_SEQ  one-cycle pulse per channel on sequence completion.
- match_count  out  NUM_SEQ*CNT_W  flattened counters; channel i occupies bits [i*CNT_W +: CNT_W].
- progress  out  NUM_SEQ*($clog2(MAX_LEN)+1)  flattened per-channel step pointer.
- count_sat  out  NUM_SEQ  sticky per-channel saturation flag.

Behaviour:
- Reset: reset_n is synchronous, active-low; clock is clk. On reset:
  - all outputs are 0;
  - all lengths are 0, so every channel is disabled;
  - the pattern RAM is cleared to 0;
  - all pointers are 0.
- Per channel state: pointer p in 0..len-1 and a registered pattern array pat[0..MAX_LEN-1].
- Update rule on instr_valid for an enabled channel (len >= 1):
  - Hit (instr_class == pat[p]) with p == len-1:
    - match_pulse[i] is 1 in the following cycle (1-cycle latency);
    - counter increments;
    - p <= 0, so matching is non-overlapping.
  - Hit with p < len-1: p <= p+1.
  - Miss, but instr_class == pat[0]: p <= 1. If len == 1, this case is a hit.
  - Miss otherwise: p <= 0.
- No instr_valid: p holds; match_pulse is 0.
- Disabled channel (len == 0): p stays 0; no pulses; counter holds.
- Configuration writes:
  - cfg_wr or cfg_len_wr to channel i resets p_i to 0 in the same clock edge.
  - A config write has priority over a simultaneous instr_valid for that channel; that instruction is ignored for channel i only.
  - Other channels process the instruction normally.
  - cfg_len values above MAX_LEN are clamped to MAX_LEN.
  - cfg_wr and cfg_len_wr asserted together: both take effect.
- Counters:
  - Saturate at all ones; count_sat[i] then sets and stays set until clr_counts or reset.
  - clr_counts zeroes all counters and flags but does not touch pointers or patterns.
  - clr_counts coincident with a completion: clear wins, and the counter reads 0. match_pulse still fires.
- Reset mid-sequence: all state returns to reset values on the next edge; partial progress is discarded.
- Back-to-back instr_valid on consecutive cycles is fully supported, one instruction per cycle.

Optional Feature:
- Macro: PDP8_SEQ_COV_TIMEOUT_EN.
- When defined:
  - Each channel has a gap counter, cleared on every instr_valid.
  - If p > 0 and TIMEOUT_CYC cycles elapse with no instr_valid, p <= 0 on the next edge.
  - A sticky output timeout_seen [NUM_SEQ] sets at that point and clears on clr_counts or reset.
- When undefined:
  - No gap counters and no timeout_seen port.
  - Pointers hold indefinitely between instructions.

Test Plan:
- Program ch0 = {11,1,1,3,12,5}, len 6 (CLA_CLL, TAD, TAD, DCA, HLT, JMP); drive those classes on consecutive instr_valid -> match_pulse[0] high exactly 1 cycle after the JMP strobe; match_count[0] = 1; progress[0] = 0.
- Ch0 as above; drive 11,1,11,1,1,3,12,5 -> the third strobe (11) restarts at p = 1; exactly one match; count = 1.
- Ch1 = {1,1}, len 2; drive 1,1,1,1 -> two matches, non-overlapping; count[1] = 2. Ch2 disabled (len 0) -> count[2] = 0 and no pulses.
- Force CNT_W = 4; complete ch0 16 times -> count stays 15 and count_sat[0] = 1; then pulse clr_counts -> count 0, sat 0.
- Ch0 at p = 3; cfg_wr to ch0 in the same cycle as instr_valid carrying class 3 -> p[0] = 0, no match; ch1 processes the instruction normally. Reset asserted with p = 4 -> all outputs 0 next cycle.
- With PDP8_SEQ_COV_TIMEOUT_EN, TIMEOUT_CYC = 64: ch0 at p = 2, no strobes for 64 cycles -> p[0] = 0 and timeout_seen[0] = 1. With a gap of 63 cycles -> p[0] stays 2.

Source files
------------

// File: rtl/pdp8_seq_cov_monitor.sv
// pdp8_seq_cov_monitor
//
// Instruction-sequence coverage monitor for the PDP8 simulator bench. It
// follows NUM_SEQ independent, run-time programmable sequences of
// instruction classes against the decoded instruction stream. It counts
// each completed sequence per channel. Matching is non-overlapping: after a
// completion the channel starts again from step 0.
//
// Optional feature (macro PDP8_SEQ_COV_TIMEOUT_EN):
//   When this macro is defined, each channel has an idle-gap counter. If a
//   channel has partial progress and no instruction arrives for TIMEOUT_CYC
//   cycles, its pointer returns to 0 and the sticky timeout_seen bit sets.
//   When the macro is undefined, pointers hold indefinitely between
//   instructions.
//
// Ports:
//   clk, reset_n   clock and synchronous active-low reset
//   instr_valid    one-cycle strobe per decoded instruction
//   instr_class    encoded instruction class, qualified by instr_valid
//   cfg_wr         write pattern step cfg_step of channel cfg_sel with cfg_class
//   cfg_len_wr     write length cfg_len of channel cfg_sel (0 disables,
//                  values above MAX_LEN are clamped)
//   clr_counts     clear all counters, saturation and timeout flags
//   match_pulse    per-channel completion pulse, one cycle after the final strobe
//   match_count    flattened per-channel saturating counters
//   progress       flattened per-channel step pointer
//   count_sat      sticky per-channel saturation flag
//   timeout_seen   sticky per-channel timeout flag (optional feature only)
module pdp8_seq_cov_monitor #(
  parameter int NUM_SEQ     = 4,
  parameter int MAX_LEN     = 8,
  parameter int OPC_W       = 5,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 64,
  localparam int SEL_W  = (NUM_SEQ > 1) ? $clog2(NUM_SEQ) : 1,
  localparam int STEP_W = $clog2(MAX_LEN),
  localparam int PTR_W  = STEP_W + 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       instr_valid,
  input  logic [OPC_W-1:0]           instr_class,
  input  logic                       cfg_wr,
  input  logic                       cfg_len_wr,
  input  logic [SEL_W-1:0]           cfg_sel,
  input  logic [STEP_W-1:0]          cfg_step,
  input  logic [OPC_W-1:0]           cfg_class,
  input  logic [PTR_W-1:0]           cfg_len,
  input  logic                       clr_counts,
  output logic [NUM_SEQ-1:0]         match_pulse,
  output logic [NUM_SEQ*CNT_W-1:0]   match_count,
  output logic [NUM_SEQ*PTR_W-1:0]   progress,
  output logic [NUM_SEQ-1:0]         count_sat
`ifdef PDP8_SEQ_COV_TIMEOUT_EN
  ,
  output logic [NUM_SEQ-1:0]         timeout_seen
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [OPC_W-1:0]  pat     [NUM_SEQ][MAX_LEN];
  logic [PTR_W-1:0]  len_q   [NUM_SEQ];
  logic [PTR_W-1:0]  ptr_q   [NUM_SEQ];
  logic [PTR_W-1:0]  ptr_d   [NUM_SEQ];
  logic [CNT_W-1:0]  cnt_q   [NUM_SEQ];
  logic [NUM_SEQ-1:0] sat_q;
  logic [NUM_SEQ-1:0] pulse_q;
  logic [NUM_SEQ-1:0] done_d;
  logic [NUM_SEQ-1:0] cfg_hit;
  logic [NUM_SEQ-1:0] cur_hit;
  logic [NUM_SEQ-1:0] first_hit;
  logic [NUM_SEQ-1:0] at_last;
  logic [PTR_W-1:0]  len_clamped;

`ifdef PDP8_SEQ_COV_TIMEOUT_EN
  localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYC - 1);
  logic [GAP_W-1:0]  gap_q   [NUM_SEQ];
  logic [NUM_SEQ-1:0] to_d;
  logic [NUM_SEQ-1:0] to_seen_q;
`endif

  assign len_clamped = (cfg_len > PTR_W'(MAX_LEN)) ? PTR_W'(MAX_LEN) : cfg_len;

  // Next pointer and completion per channel. A config write to a channel
  // wins over a simultaneous instruction for that channel only. A miss that
  // equals step 0 restarts the sequence at step 1 instead of dropping it.
  always_comb begin
    for (int i = 0; i < NUM_SEQ; i++) begin
      cfg_hit[i]   = (cfg_wr || cfg_len_wr) && (cfg_sel == SEL_W'(i));
      cur_hit[i]   = (instr_class == pat[i][ptr_q[i][STEP_W-1:0]]);
      first_hit[i] = (instr_class == pat[i][0]);
      at_last[i]   = (ptr_q[i] == len_q[i] - PTR_W'(1));
      ptr_d[i]     = ptr_q[i];
      done_d[i]    = 1'b0;
`ifdef PDP8_SEQ_COV_TIMEOUT_EN
      to_d[i]      = 1'b0;
`endif
      if (cfg_hit[i] || (len_q[i] == '0)) begin
        ptr_d[i] = '0;
      end else if (instr_valid) begin
        if (cur_hit[i] && at_last[i]) begin
          ptr_d[i]  = '0;
          done_d[i] = 1'b1;
        end else if (cur_hit[i]) begin
          ptr_d[i] = ptr_q[i] + PTR_W'(1);
        end else if (first_hit[i]) begin
          if (len_q[i] == PTR_W'(1)) begin
            ptr_d[i]  = '0;
            done_d[i] = 1'b1;
          end else begin
            ptr_d[i] = PTR_W'(1);
          end
        end else begin
          ptr_d[i] = '0;
        end
      end
`ifdef PDP8_SEQ_COV_TIMEOUT_EN
      else if ((ptr_q[i] != '0) && (gap_q[i] == GAP_LIMIT)) begin
        ptr_d[i] = '0;
        to_d[i]  = 1'b1;
      end
`endif
    end
  end

  // State registers: pattern RAM, lengths, pointers, pulses, and counters.
  // The saturation flag sets as the counter reaches all ones. A clear wins
  // over a coincident completion, but the pulse still fires.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SEQ; i++) begin
        for (int j = 0; j < MAX_LEN; j++) begin
          pat[i][j] <= '0;
        end
        len_q[i] <= '0;
        ptr_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      sat_q   <= '0;
      pulse_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SEQ; i++) begin
        ptr_q[i]   <= ptr_d[i];
        pulse_q[i] <= done_d[i];
        if (cfg_wr && (cfg_sel == SEL_W'(i)) && (int'(cfg_step) < MAX_LEN)) begin
          pat[i][cfg_step] <= cfg_class;
        end
        if (cfg_len_wr && (cfg_sel == SEL_W'(i))) begin
          len_q[i] <= len_clamped;
        end
        if (clr_counts) begin
          cnt_q[i] <= '0;
          sat_q[i] <= 1'b0;
        end else if (done_d[i]) begin
          if (cnt_q[i] != CNT_MAX) begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
          if ((cnt_q[i] == CNT_MAX) || (cnt_q[i] == CNT_MAX - CNT_W'(1))) begin
            sat_q[i] <= 1'b1;
          end
        end
      end
    end
  end

`ifdef PDP8_SEQ_COV_TIMEOUT_EN
  // Idle-gap counters restart on every instruction and stop at the limit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SEQ; i++) begin
        gap_q[i] <= '0;
      end
      to_seen_q <= '0;
    end else begin
      for (int i = 0; i < NUM_SEQ; i++) begin
        if (instr_valid) begin
          gap_q[i] <= '0;
        end else if (gap_q[i] != GAP_LIMIT) begin
          gap_q[i] <= gap_q[i] + GAP_W'(1);
        end
        if (clr_counts) begin
          to_seen_q[i] <= 1'b0;
        end else if (to_d[i]) begin
          to_seen_q[i] <= 1'b1;
        end
      end
    end
  end

  assign timeout_seen = to_seen_q;
`endif

  for (genvar g = 0; g < NUM_SEQ; g++) begin : g_flat
    assign match_count[g*CNT_W +: CNT_W] = cnt_q[g];
    assign progress[g*PTR_W +: PTR_W]    = ptr_q[g];
  end

  assign match_pulse = pulse_q;
  assign count_sat   = sat_q;

endmodule

// File: tb/tb_pdp8_seq_cov_monitor.sv
// tb_pdp8_seq_cov_monitor
//
// Directed bench for pdp8_seq_cov_monitor built with 4 channels, 8 steps
// and 4-bit counters, so saturation is reached quickly. Each test task
// drives its own scenario and compares against hand-computed values.
module tb_pdp8_seq_cov_monitor;

  localparam int NUM_SEQ = 4;
  localparam int MAX_LEN = 8;
  localparam int OPC_W   = 5;
  localparam int CNT_W   = 4;
  localparam int PTR_W   = 4;

  logic                       clk;
  logic                       reset_n;
  logic                       instr_valid;
  logic [OPC_W-1:0]           instr_class;
  logic                       cfg_wr;
  logic                       cfg_len_wr;
  logic [1:0]                 cfg_sel;
  logic [2:0]                 cfg_step;
  logic [OPC_W-1:0]           cfg_class;
  logic [PTR_W-1:0]           cfg_len;
  logic                       clr_counts;
  logic [NUM_SEQ-1:0]         match_pulse;
  logic [NUM_SEQ*CNT_W-1:0]   match_count;
  logic [NUM_SEQ*PTR_W-1:0]   progress;
  logic [NUM_SEQ-1:0]         count_sat;

  int total = 0;
  int bad   = 0;

  pdp8_seq_cov_monitor #(
    .NUM_SEQ(NUM_SEQ),
    .MAX_LEN(MAX_LEN),
    .OPC_W(OPC_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .instr_valid(instr_valid),
    .instr_class(instr_class),
    .cfg_wr(cfg_wr),
    .cfg_len_wr(cfg_len_wr),
    .cfg_sel(cfg_sel),
    .cfg_step(cfg_step),
    .cfg_class(cfg_class),
    .cfg_len(cfg_len),
    .clr_counts(clr_counts),
    .match_pulse(match_pulse),
    .match_count(match_count),
    .progress(progress),
    .count_sat(count_sat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Run-time bound: the whole bench needs well under 1000 cycles.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int cnt(input int ch);
    return int'(match_count[ch*CNT_W +: CNT_W]);
  endfunction

  function automatic int prog(input int ch);
    return int'(progress[ch*PTR_W +: PTR_W]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [OPC_W-1:0] cls);
    instr_valid = 1'b1;
    instr_class = cls;
    tick();
    instr_valid = 1'b0;
    instr_class = '0;
  endtask

  task automatic write_step(input int ch, input int step, input int cls);
    cfg_wr    = 1'b1;
    cfg_sel   = 2'(ch);
    cfg_step  = 3'(step);
    cfg_class = OPC_W'(cls);
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic write_len(input int ch, input int len);
    cfg_len_wr = 1'b1;
    cfg_sel    = 2'(ch);
    cfg_len    = PTR_W'(len);
    tick();
    cfg_len_wr = 1'b0;
  endtask

  task automatic pulse_clear();
    clr_counts = 1'b1;
    tick();
    clr_counts = 1'b0;
  endtask

  task automatic program_ch0();
    int seq [6] = '{11, 1, 1, 3, 12, 5};
    for (int k = 0; k < 6; k++) write_step(0, k, seq[k]);
    write_len(0, 6);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    total++; if (match_pulse !== 4'h0) begin bad++; $display("[TB] FAIL reset_pulse: got %h want 0", match_pulse); end
    total++; if (match_count !== 16'h0) begin bad++; $display("[TB] FAIL reset_count: got %h want 0", match_count); end
    total++; if (progress !== 16'h0) begin bad++; $display("[TB] FAIL reset_progress: got %h want 0", progress); end
    total++; if (count_sat !== 4'h0) begin bad++; $display("[TB] FAIL reset_sat: got %h want 0", count_sat); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_seq();
    int seq [6] = '{11, 1, 1, 3, 12, 5};
    program_ch0();
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(OPC_W'(seq[k]));
      total++; if (prog(0) != k + 1) begin bad++; $display("[TB] FAIL basic_progress step %0d: got %0d want %0d", k, prog(0), k + 1); end
      total++; if (match_pulse[0] !== 1'b0) begin bad++; $display("[TB] FAIL basic_early_pulse step %0d: got %b want 0", k, match_pulse[0]); end
    end
    apply_stimulus(5'd5);
    total++; if (match_pulse[0] !== 1'b1) begin bad++; $display("[TB] FAIL basic_pulse: got %b want 1", match_pulse[0]); end
    total++; if (cnt(0) != 1) begin bad++; $display("[TB] FAIL basic_count: got %0d want 1", cnt(0)); end
    total++; if (prog(0) != 0) begin bad++; $display("[TB] FAIL basic_progress_end: got %0d want 0", prog(0)); end
    tick();
    total++; if (match_pulse[0] !== 1'b0) begin bad++; $display("[TB] FAIL basic_pulse_width: got %b want 0", match_pulse[0]); end
  endtask

  task automatic test_restart();
    int seq [8] = '{11, 1, 11, 1, 1, 3, 12, 5};
    int pulses = 0;
    pulse_clear();
    total++; if (cnt(0) != 0) begin bad++; $display("[TB] FAIL restart_clear: got %0d want 0", cnt(0)); end
    for (int k = 0; k < 8; k++) begin
      apply_stimulus(OPC_W'(seq[k]));
      if (match_pulse[0] === 1'b1) pulses++;
      if (k == 2) begin
        total++; if (prog(0) != 1) begin bad++; $display("[TB] FAIL restart_progress: got %0d want 1", prog(0)); end
      end
    end
    total++; if (match_pulse[0] !== 1'b1) begin bad++; $display("[TB] FAIL restart_last_pulse: got %b want 1", match_pulse[0]); end
    total++; if (pulses != 1) begin bad++; $display("[TB] FAIL restart_pulses: got %0d want 1", pulses); end
    total++; if (cnt(0) != 1) begin bad++; $display("[TB] FAIL restart_count: got %0d want 1", cnt(0)); end
  endtask

  task automatic test_idle_hold();
    apply_stimulus(5'd11);
    apply_stimulus(5'd1);
    for (int k = 0; k < 5; k++) tick();
    total++; if (prog(0) != 2) begin bad++; $display("[TB] FAIL idle_hold: got %0d want 2", prog(0)); end
    total++; if (match_pulse !== 4'h0) begin bad++; $display("[TB] FAIL idle_pulse: got %h want 0", match_pulse); end
    apply_stimulus(5'd0);
    total++; if (prog(0) != 0) begin bad++; $display("[TB] FAIL idle_miss: got %0d want 0", prog(0)); end
  endtask

  task automatic test_nonoverlap();
    int p1 = 0;
    int p2 = 0;
    write_step(1, 0, 1);
    write_step(1, 1, 1);
    write_len(1, 2);
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(5'd1);
      if (match_pulse[1] === 1'b1) p1++;
      if (match_pulse[2] === 1'b1) p2++;
      if (k == 0) begin
        total++; if (prog(1) != 1) begin bad++; $display("[TB] FAIL nonoverlap_progress: got %0d want 1", prog(1)); end
      end
    end
    total++; if (p1 != 2) begin bad++; $display("[TB] FAIL nonoverlap_pulses: got %0d want 2", p1); end
    total++; if (cnt(1) != 2) begin bad++; $display("[TB] FAIL nonoverlap_count: got %0d want 2", cnt(1)); end
    total++; if (cnt(2) != 0) begin bad++; $display("[TB] FAIL disabled_count: got %0d want 0", cnt(2)); end
    total++; if (p2 != 0) begin bad++; $display("[TB] FAIL disabled_pulses: got %0d want 0", p2); end
  endtask

  task automatic test_len_clamp();
    for (int k = 0; k < 8; k++) write_step(2, k, 2);
    write_len(2, 15);
    for (int k = 0; k < 7; k++) apply_stimulus(5'd2);
    total++; if (prog(2) != 7) begin bad++; $display("[TB] FAIL clamp_progress: got %0d want 7", prog(2)); end
    total++; if (match_pulse[2] !== 1'b0) begin bad++; $display("[TB] FAIL clamp_early: got %b want 0", match_pulse[2]); end
    apply_stimulus(5'd2);
    total++; if (match_pulse[2] !== 1'b1) begin bad++; $display("[TB] FAIL clamp_pulse: got %b want 1", match_pulse[2]); end
    total++; if (cnt(2) != 1) begin bad++; $display("[TB] FAIL clamp_count: got %0d want 1", cnt(2)); end
  endtask

  task automatic test_back_to_back();
    write_step(3, 0, 7);
    write_len(3, 1);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(5'd7);
      total++; if (match_pulse[3] !== 1'b1) begin bad++; $display("[TB] FAIL b2b_pulse %0d: got %b want 1", k, match_pulse[3]); end
    end
    total++; if (cnt(3) != 3) begin bad++; $display("[TB] FAIL b2b_count: got %0d want 3", cnt(3)); end
    total++; if (prog(3) != 0) begin bad++; $display("[TB] FAIL b2b_progress: got %0d want 0", prog(3)); end
  endtask

  task automatic test_saturation();
    int seq [6] = '{11, 1, 1, 3, 12, 5};
    pulse_clear();
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 6; k++) apply_stimulus(OPC_W'(seq[k]));
    end
    total++; if (cnt(0) != 15) begin bad++; $display("[TB] FAIL sat_count: got %0d want 15", cnt(0)); end
    total++; if (count_sat[0] !== 1'b1) begin bad++; $display("[TB] FAIL sat_flag: got %b want 1", count_sat[0]); end
    total++; if (count_sat[3] !== 1'b0) begin bad++; $display("[TB] FAIL sat_flag_ch3: got %b want 0", count_sat[3]); end
    pulse_clear();
    total++; if (cnt(0) != 0) begin bad++; $display("[TB] FAIL sat_clear_count: got %0d want 0", cnt(0)); end
    total++; if (count_sat !== 4'h0) begin bad++; $display("[TB] FAIL sat_clear_flag: got %h want 0", count_sat); end
    clr_counts = 1'b1;
    apply_stimulus(5'd7);
    clr_counts = 1'b0;
    total++; if (match_pulse[3] !== 1'b1) begin bad++; $display("[TB] FAIL clr_race_pulse: got %b want 1", match_pulse[3]); end
    total++; if (cnt(3) != 0) begin bad++; $display("[TB] FAIL clr_race_count: got %0d want 0", cnt(3)); end
  endtask

  task automatic test_cfg_priority();
    write_step(1, 0, 3);
    write_step(1, 1, 3);
    write_len(1, 2);
    apply_stimulus(5'd11);
    apply_stimulus(5'd1);
    apply_stimulus(5'd1);
    total++; if (prog(0) != 3) begin bad++; $display("[TB] FAIL prio_setup: got %0d want 3", prog(0)); end
    cfg_wr      = 1'b1;
    cfg_sel     = 2'd0;
    cfg_step    = 3'd0;
    cfg_class   = 5'd11;
    instr_valid = 1'b1;
    instr_class = 5'd3;
    tick();
    cfg_wr      = 1'b0;
    instr_valid = 1'b0;
    total++; if (prog(0) != 0) begin bad++; $display("[TB] FAIL prio_ptr: got %0d want 0", prog(0)); end
    total++; if (match_pulse[0] !== 1'b0) begin bad++; $display("[TB] FAIL prio_pulse: got %b want 0", match_pulse[0]); end
    total++; if (prog(1) != 1) begin bad++; $display("[TB] FAIL prio_other_ch: got %0d want 1", prog(1)); end
  endtask

  task automatic test_reset_mid();
    apply_stimulus(5'd11);
    apply_stimulus(5'd1);
    apply_stimulus(5'd1);
    apply_stimulus(5'd3);
    total++; if (prog(0) != 4) begin bad++; $display("[TB] FAIL mid_setup: got %0d want 4", prog(0)); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    total++; if (progress !== 16'h0) begin bad++; $display("[TB] FAIL mid_progress: got %h want 0", progress); end
    total++; if (match_count !== 16'h0) begin bad++; $display("[TB] FAIL mid_count: got %h want 0", match_count); end
    total++; if (match_pulse !== 4'h0) begin bad++; $display("[TB] FAIL mid_pulse: got %h want 0", match_pulse); end
    total++; if (count_sat !== 4'h0) begin bad++; $display("[TB] FAIL mid_sat: got %h want 0", count_sat); end
    apply_stimulus(5'd11);
    total++; if (prog(0) != 0) begin bad++; $display("[TB] FAIL mid_disabled: got %0d want 0", prog(0)); end
  endtask

  initial begin
    reset_n     = 1'b0;
    instr_valid = 1'b0;
    instr_class = '0;
    cfg_wr      = 1'b0;
    cfg_len_wr  = 1'b0;
    cfg_sel     = '0;
    cfg_step    = '0;
    cfg_class   = '0;
    cfg_len     = '0;
    clr_counts  = 1'b0;
    test_reset();
    test_basic_seq();
    test_restart();
    test_idle_hold();
    test_nonoverlap();
    test_len_clamp();
    test_back_to_back();
    test_saturation();
    test_cfg_priority();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
